vmicro16_apb_rr_intercon: RTL and testbench

//  Parametrised N-master / M-slave APB interconnect for the vmicro16 SoC.

---
 rtl/vmicro16_apb_rr_intercon_pkg.sv | 19 +
 rtl/vmicro16_apb_rr_intercon_if.sv | 39 +++
 rtl/vmicro16_apb_rr_intercon_arbiter.sv | 33 +++
 rtl/vmicro16_apb_rr_intercon.sv | 156 +++++++++++++++
 tb/tb_vmicro16_apb_rr_intercon.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmicro16_apb_rr_intercon_pkg.sv
// Shared constants and types for the vmicro16 round-robin APB interconnect.
// FSM encoding, default slave-select field placement, index-width helper.
package vmicro16_apb_rr_intercon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int DEF_SEL_LSB = 4;
   localparam int DEF_SEL_W   = 3;

   // Width of an index into n items; a single item still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vmicro16_apb_rr_intercon_if.sv
// Bus bundle for the interconnect: per-core S_* side and shared slave-facing M_* side.
// The slave modport is the interconnect's view; master is the cores/peripherals view.
interface vmicro16_apb_rr_intercon_if #(
   parameter int MASTER_PORTS = 4,
   parameter int SLAVE_PORTS  = 8,
   parameter int BUS_WIDTH    = 16,
   parameter int DATA_WIDTH   = 16
);
   logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR;
   logic [MASTER_PORTS-1:0]            S_PWRITE;
   logic [MASTER_PORTS-1:0]            S_PSELx;
   logic [MASTER_PORTS-1:0]            S_PENABLE;
   logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA;
   logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA;
   logic [MASTER_PORTS-1:0]            S_PREADY;
   logic [MASTER_PORTS-1:0]            S_PSLVERR;

   logic [BUS_WIDTH-1:0]               M_PADDR;
   logic                               M_PWRITE;
   logic [SLAVE_PORTS-1:0]             M_PSELx;
   logic                               M_PENABLE;
   logic [DATA_WIDTH-1:0]              M_PWDATA;
   logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA;
   logic [SLAVE_PORTS-1:0]             M_PREADY;

   modport slave (
      input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
      output S_PRDATA, S_PREADY, S_PSLVERR,
      output M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
      input  M_PRDATA, M_PREADY
   );

   modport master (
      output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
      input  S_PRDATA, S_PREADY, S_PSLVERR,
      input  M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
      output M_PRDATA, M_PREADY
   );
endinterface

// File: rtl/vmicro16_apb_rr_intercon_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, scanning upward with wrap.
// Produces both a one-hot grant and its binary index.
module vmicro16_rr_arbiter
   import vmicro16_apb_rr_intercon_pkg::*;
#(
   parameter int MASTER_PORTS = 4
) (
   input  logic [MASTER_PORTS-1:0]            req,
   input  logic [idx_width(MASTER_PORTS)-1:0] ptr,
   output logic [MASTER_PORTS-1:0]            gnt,
   output logic [idx_width(MASTER_PORTS)-1:0] idx,
   output logic                               any
);
   localparam int GW = idx_width(MASTER_PORTS);

   int unsigned cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = 0;
      for (int unsigned k = 0; k < MASTER_PORTS; k++) begin
         cand = (32'(ptr) + k) % MASTER_PORTS;
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = GW'(cand);
         end
      end
   end

endmodule

// File: rtl/vmicro16_apb_rr_intercon.sv
// N-master / M-slave APB interconnect with round-robin arbitration and one-hot slave decode.
// Optional ACCESS-phase timeout is built when APB_INTERCON_TIMEOUT_EN is defined.
module vmicro16_apb_rr_intercon
   import vmicro16_apb_rr_intercon_pkg::*;
#(
   parameter int MASTER_PORTS   = 4,
   parameter int SLAVE_PORTS    = 8,
   parameter int BUS_WIDTH      = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int SEL_LSB        = DEF_SEL_LSB,
   parameter int SEL_W          = DEF_SEL_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                               clk,
   input  logic                               reset,
   vmicro16_apb_rr_intercon_if.slave          bus,
   output logic                               busy,
   output logic [idx_width(MASTER_PORTS)-1:0] grant
);
   localparam int GW = idx_width(MASTER_PORTS);

   state_t                  state, state_next;
   logic [GW-1:0]           rr_ptr, win_idx, ptr_inc;
   logic [MASTER_PORTS-1:0] win_gnt;
   logic                    win_any;
   logic [BUS_WIDTH-1:0]    win_paddr, paddr_r;
   logic                    win_pwrite, pwrite_r;
   logic [DATA_WIDTH-1:0]   win_pwdata, pwdata_r, slave_rdata;
   logic [SEL_W-1:0]        sel_r;
   logic                    dec_err, slave_rdy, timed_out, xfer_done;

   vmicro16_rr_arbiter #(.MASTER_PORTS(MASTER_PORTS)) u_arb (
      .req (bus.S_PSELx),
      .ptr (rr_ptr),
      .gnt (win_gnt),
      .idx (win_idx),
      .any (win_any)
   );

   // One-hot AND-OR mux of the winning master's request fields.
   always_comb begin
      win_paddr  = '0;
      win_pwrite = 1'b0;
      win_pwdata = '0;
      for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
         if (win_gnt[i]) begin
            win_paddr  = win_paddr  | bus.S_PADDR[i*BUS_WIDTH +: BUS_WIDTH];
            win_pwrite = win_pwrite | bus.S_PWRITE[i];
            win_pwdata = win_pwdata | bus.S_PWDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      slave_rdy   = 1'b0;
      slave_rdata = '0;
      for (int unsigned s = 0; s < SLAVE_PORTS; s++) begin
         if (sel_r == SEL_W'(s)) begin
            slave_rdy   = bus.M_PREADY[s];
            slave_rdata = bus.M_PRDATA[s*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign dec_err = (int'(sel_r) >= SLAVE_PORTS);

`ifdef APB_INTERCON_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (!reset || state != ACCESS)
         wait_cnt <= '0;
      else if (!slave_rdy)
         wait_cnt <= wait_cnt + CW'(1);
   end

   // A slave that answers in the limit cycle still completes normally.
   assign timed_out = (state == ACCESS) && !dec_err && !slave_rdy &&
                      (wait_cnt == CW'(TIMEOUT_CYCLES));
`else
   assign timed_out = 1'b0;
`endif

   assign xfer_done = (state == ACCESS) && (dec_err || slave_rdy || timed_out);
   assign ptr_inc   = (int'(grant) == MASTER_PORTS - 1) ? '0 : grant + GW'(1);

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (win_any) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (xfer_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Transfer fields are cleared on completion so M_* reads zero whenever idle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr   <= '0;
         grant    <= '0;
         paddr_r  <= '0;
         pwrite_r <= 1'b0;
         pwdata_r <= '0;
         sel_r    <= '0;
      end else if (state == IDLE && win_any) begin
         grant    <= win_idx;
         paddr_r  <= win_paddr;
         pwrite_r <= win_pwrite;
         pwdata_r <= win_pwdata;
         sel_r    <= win_paddr[SEL_LSB +: SEL_W];
      end else if (xfer_done) begin
         rr_ptr   <= ptr_inc;
         paddr_r  <= '0;
         pwrite_r <= 1'b0;
         pwdata_r <= '0;
         sel_r    <= '0;
      end
   end

   assign busy         = (state != IDLE);
   assign bus.M_PADDR  = paddr_r;
   assign bus.M_PWRITE = pwrite_r;
   assign bus.M_PWDATA = pwdata_r;

   // Outputs are gated by reset so an abandoned transfer never leaks a PREADY.
   always_comb begin
      bus.M_PSELx   = '0;
      bus.M_PENABLE = 1'b0;
      bus.S_PREADY  = '0;
      bus.S_PSLVERR = '0;
      bus.S_PRDATA  = '0;
      if (reset && state != IDLE) begin
         for (int unsigned s = 0; s < SLAVE_PORTS; s++)
            bus.M_PSELx[s] = !dec_err && !timed_out && (sel_r == SEL_W'(s));
         bus.M_PENABLE = (state == ACCESS) && !timed_out;
         for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
            if (xfer_done && grant == GW'(i)) begin
               bus.S_PREADY[i]  = 1'b1;
               bus.S_PSLVERR[i] = dec_err || timed_out;
               bus.S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] =
                  (dec_err || timed_out) ? '0 : slave_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_vmicro16_apb_rr_intercon.sv
// Scoreboard bench for vmicro16_apb_rr_intercon: random batches plus directed latency/decode/wait/reset cases.
// Covers the ACCESS timeout path when APB_INTERCON_TIMEOUT_EN is defined.
module tb_vmicro16_apb_rr_intercon;
   localparam int M       = 4;
   localparam int S       = 6;
   localparam int BW      = 16;
   localparam int DW      = 16;
   localparam int SEL_LSB = 4;
   localparam int SEL_W   = 3;
   localparam int TO      = 8;
   localparam int GW      = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          busy;
   logic [GW-1:0] grant;

   vmicro16_apb_rr_intercon_if #(
      .MASTER_PORTS(M), .SLAVE_PORTS(S), .BUS_WIDTH(BW), .DATA_WIDTH(DW)
   ) bus ();

   vmicro16_apb_rr_intercon #(
      .MASTER_PORTS(M), .SLAVE_PORTS(S), .BUS_WIDTH(BW), .DATA_WIDTH(DW),
      .SEL_LSB(SEL_LSB), .SEL_W(SEL_W), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy),
      .grant (grant)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned   master;
      logic [BW-1:0] addr;
      logic          write;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          slverr;
      logic [S-1:0]  psel;
      logic          penable;
   } exp_t;

   exp_t          exp_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] ref_mem [128];
   int unsigned   ref_ptr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [DW-1:0] init_val(input int unsigned a);
      return DW'(a * 37 + 32'h5A00);
   endfunction

   // Reference: a transfer reads the word currently at its address, then writes it if PWRITE.
   function automatic exp_t predict(input int unsigned m, input logic [BW-1:0] a,
                                    input logic w, input logic [DW-1:0] wd, input bit to);
      exp_t        e;
      int unsigned idx;
      idx       = 32'(a[SEL_LSB +: SEL_W]);
      e.master  = m;
      e.addr    = a;
      e.write   = w;
      e.wdata   = wd;
      e.rdata   = '0;
      e.slverr  = 1'b1;
      e.psel    = '0;
      e.penable = 1'b1;
      if (idx < S && to) begin
         e.penable = 1'b0;
      end else if (idx < S) begin
         e.slverr = 1'b0;
         e.rdata  = ref_mem[a[6:0]];
         e.psel   = S'(1) << idx;
         if (w) ref_mem[a[6:0]] = wd;
      end
      return e;
   endfunction

   // Slave BFM: word memory per slave, programmable wait states before PREADY.
   logic [DW-1:0] bfm_mem [S][16];
   int unsigned   bfm_cnt = 0;
   int unsigned   cur_delay = 0;
   int            fixed_delay = 0;
   bit            stall = 1'b0;

   always @(posedge clk) begin
      if (bus.M_PENABLE && bus.M_PSELx != '0) begin
         if (bfm_cnt >= cur_delay && bus.M_PWRITE)
            for (int s = 0; s < S; s++)
               if (bus.M_PSELx[s]) bfm_mem[s][bus.M_PADDR[3:0]] <= bus.M_PWDATA;
         bfm_cnt <= bfm_cnt + 1;
      end else begin
         bfm_cnt   <= 0;
         cur_delay <= stall ? 100000 : (fixed_delay >= 0 ? fixed_delay : $urandom_range(0, 3));
      end
   end

   always_comb begin
      for (int s = 0; s < S; s++) begin
         bus.M_PREADY[s] = (bfm_cnt >= cur_delay);
         bus.M_PRDATA[s*DW +: DW] = bfm_mem[s][bus.M_PADDR[3:0]];
      end
   end

   // Monitor: pops the scoreboard on every S_PREADY and checks non-granted outputs stay quiet.
   exp_t        mon_e;
   int unsigned mon_m;
   logic        leak;

   always @(negedge clk) begin
      leak = 1'b0;
      for (int i = 0; i < M; i++)
         if (!bus.S_PREADY[i] && (bus.S_PSLVERR[i] || bus.S_PRDATA[i*DW +: DW] != '0)) leak = 1'b1;
      check("idle_master_outputs", 32'(leak), 32'd0);
      if (bus.S_PREADY != '0) begin
         if ($countones(bus.S_PREADY) != 1 || exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pready: got S_PREADY=0x%0h with %0d queued, required one-hot with a queued transfer",
                     bus.S_PREADY, exp_q.size());
         end else begin
            mon_e = exp_q.pop_front();
            mon_m = 0;
            for (int i = 0; i < M; i++) if (bus.S_PREADY[i]) mon_m = i;
            check("served_master", mon_m, mon_e.master);
            check("grant_out", 32'(grant), mon_e.master);
            check("s_pslverr", 32'(bus.S_PSLVERR[mon_m]), 32'(mon_e.slverr));
            check("s_prdata", 32'(bus.S_PRDATA[mon_m*DW +: DW]), 32'(mon_e.rdata));
            check("m_paddr", 32'(bus.M_PADDR), 32'(mon_e.addr));
            check("m_pwrite", 32'(bus.M_PWRITE), 32'(mon_e.write));
            if (mon_e.write) check("m_pwdata", 32'(bus.M_PWDATA), 32'(mon_e.wdata));
            check("m_psel", 32'(bus.M_PSELx), 32'(mon_e.psel));
            check("m_penable", 32'(bus.M_PENABLE), 32'(mon_e.penable));
         end
      end
   end

   task automatic setup_req(input int unsigned m, input logic [BW-1:0] a,
                            input logic w, input logic [DW-1:0] wd);
      bus.S_PADDR[m*BW +: BW]  = a;
      bus.S_PWRITE[m]          = w;
      bus.S_PWDATA[m*DW +: DW] = wd;
      bus.S_PSELx[m]           = 1'b1;
      bus.S_PENABLE[m]         = 1'b1;
   endtask

   task automatic drop_req(input logic [M-1:0] mask);
      bus.S_PSELx   = bus.S_PSELx & ~mask;
      bus.S_PENABLE = bus.S_PENABLE & ~mask;
   endtask

   // All requests in the set are raised together while the interconnect is idle.
   task automatic launch(input logic [M-1:0] req_set, input bit early);
      logic [M-1:0] pending = req_set;
      logic [M-1:0] served;
      int unsigned  first_m = 0, last_m = 0, budget = 0, m;
      bit           have = 1'b0;
      for (int unsigned k = 0; k < M; k++) begin
         m = (ref_ptr + k) % M;
         if (req_set[m]) begin
            exp_q.push_back(predict(m, bus.S_PADDR[m*BW +: BW], bus.S_PWRITE[m],
                                    bus.S_PWDATA[m*DW +: DW], 1'b0));
            if (!have) first_m = m;
            have   = 1'b1;
            last_m = m;
         end
      end
      if (have) ref_ptr = (last_m + 1) % M;
      while (pending != '0 && budget < 500) begin
         @(negedge clk);
         served = bus.S_PREADY;
         @(posedge clk);
         #1;
         pending = pending & ~served;
         drop_req(served);
         if (early && busy && 32'(grant) == first_m) drop_req(M'(1) << first_m);
         budget++;
      end
      if (pending != '0) check("batch_completion_timeout", 32'(pending), 32'd0);
   endtask

   task automatic directed(input int unsigned m, input logic [BW-1:0] a, input logic w,
                           input logic [DW-1:0] wd, input bit to, input int unsigned exp_acc);
      int unsigned  idx = 32'(a[SEL_LSB +: SEL_W]);
      int unsigned  acc = 0;
      bit           got = 1'b0;
      logic [S-1:0] exp_sel;
      exp_sel = (idx < S) ? (S'(1) << idx) : '0;
      setup_req(m, a, w, wd);
      exp_q.push_back(predict(m, a, w, wd, to));
      ref_ptr = (m + 1) % M;
      @(negedge clk);
      check("idle_cycle_psel", 32'(bus.M_PSELx), 32'd0);
      @(negedge clk);
      check("setup_psel", 32'(bus.M_PSELx), 32'(exp_sel));
      check("setup_penable", 32'(bus.M_PENABLE), 32'd0);
      check("setup_paddr", 32'(bus.M_PADDR), 32'(a));
      while (!got && acc < 40) begin
         @(negedge clk);
         acc++;
         check("access_paddr_stable", 32'(bus.M_PADDR), 32'(a));
         if (bus.S_PREADY[m]) got = 1'b1;
      end
      check("access_cycles", acc, exp_acc);
      @(posedge clk);
      #1;
      drop_req(M'(1) << m);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [M-1:0] rs;
      bus.S_PADDR   = '0;
      bus.S_PWRITE  = '0;
      bus.S_PSELx   = '0;
      bus.S_PENABLE = '0;
      bus.S_PWDATA  = '0;
      for (int unsigned a = 0; a < 128; a++) ref_mem[a] = init_val(a);
      for (int unsigned s = 0; s < S; s++)
         for (int unsigned o = 0; o < 16; o++) bfm_mem[s][o] = init_val(s * 16 + o);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_grant", 32'(grant), 32'd0);
      check("reset_m_psel", 32'(bus.M_PSELx), 32'd0);
      check("reset_m_penable", 32'(bus.M_PENABLE), 32'd0);
      check("reset_m_paddr", 32'(bus.M_PADDR), 32'd0);
      check("reset_s_pready", 32'(bus.S_PREADY), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      fixed_delay = 0;
      directed(0, 16'h0012, 1'b1, 16'hBEEF, 1'b0, 1);
      directed(0, 16'h0070, 1'b0, 16'h0000, 1'b0, 1);
      directed(1, 16'h0025, 1'b1, 16'h1234, 1'b0, 1);
      fixed_delay = 5;
      directed(1, 16'h0025, 1'b0, 16'h0000, 1'b0, 6);

      // Abandon an ACCESS with reset; rr pointer (2 here) must return to 0.
      fixed_delay = 20;
      setup_req(2, 16'h0031, 1'b0, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_penable", 32'(bus.M_PENABLE), 32'd1);
      reset = 1'b0;
      drop_req(4'b0100);
      #1;
      check("reset_cycle_s_pready", 32'(bus.S_PREADY), 32'd0);
      @(negedge clk);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_grant", 32'(grant), 32'd0);
      check("midreset_m_psel", 32'(bus.M_PSELx), 32'd0);
      check("midreset_m_penable", 32'(bus.M_PENABLE), 32'd0);
      check("midreset_m_paddr", 32'(bus.M_PADDR), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      ref_ptr = 0;
      fixed_delay = -1;

      for (int unsigned i = 0; i < 3; i++)
         setup_req(i, BW'($urandom_range(0, 127)), 1'($urandom), DW'($urandom));
      launch(4'b0111, 1'b0);
      setup_req(0, 16'h0014, 1'b0, 16'h0000);
      launch(4'b0001, 1'b0);

      for (int unsigned b = 0; b < 40; b++) begin
         rs = M'($urandom_range(1, (1 << M) - 1));
         for (int unsigned i = 0; i < M; i++)
            if (rs[i]) setup_req(i, BW'($urandom_range(0, 127)), 1'($urandom), DW'($urandom));
         launch(rs, ($urandom % 4) == 0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

`ifdef APB_INTERCON_TIMEOUT_EN
      stall = 1'b1;
      directed(2, 16'h0033, 1'b0, 16'h0000, 1'b1, TO + 1);
      stall = 1'b0;
      fixed_delay = 0;
      setup_req(3, 16'h0041, 1'b1, 16'h5A5A);
      launch(4'b1000, 1'b0);
`endif

      repeat (3) @(posedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
